voice_sync_fifo: RTL and testbench
==================================

// Module: voice_sync_fifo
// PURPOSE
//  Single-clock first-word-fall-through FIFO for voice sample and packet bytes.
//  Owns the read/write pointers, occupancy and flags around one dualram storage instance.
//  Upstream: capture/codec stage pushes samples. Downstream: packetizer/transmit stage pops them.
// PARAMETERS
//  ASIZE     3  address width; depth = 2**ASIZE entries
//  DSIZE     8  data width in bits
//  AFULL_TH  6  o_afull asserts when count >= AFULL_TH (1..2**ASIZE)
//  AEMPTY_TH 1  o_aempty asserts when count <= AEMPTY_TH (0..2**ASIZE-1)
// PORTS
//  i_clk      in   1        single clock; all logic on posedge
//  i_rst_n    in   1        asynchronous reset, active-low
//  i_wr_valid in   1        write request
//  o_wr_ready out  1        space available (= !o_full)
//  i_wr_data  in   DSIZE    write data
//  o_rd_valid out  1        head entry valid (= !o_empty)
//  i_rd_ready in   1        consumer takes head this cycle
//  o_rd_data  out  DSIZE    head entry, combinational from storage
//  o_full     out  1        count == 2**ASIZE
//  o_empty    out  1        count == 0
//  o_afull    out  1        almost-full flag
//  o_aempty   out  1        almost-empty flag
//  o_count    out  ASIZE+1  current occupancy, 0..2**ASIZE
//  o_ovf      out  1        sticky: write attempted while full
//  o_unf      out  1        sticky: read attempted while empty
//  i_clr_err  in   1        synchronous clear of o_ovf/o_unf
// BEHAVIOUR
//  Interface: one clock i_clk; reset i_rst_n is asynchronous and active-low.
//  Reset:
//   - wr_ptr = rd_ptr = 0, o_count = 0.
//   - o_empty = 1, o_aempty = 1, o_full = 0, o_afull = 0, o_ovf = 0, o_unf = 0.
//   - o_rd_valid = 0, o_wr_ready = 1. Storage contents are not cleared.
//   - Reset mid-operation discards all queued entries immediately.
//  Pointers: ASIZE+1 bits each; the low ASIZE bits address storage; the MSB is the wrap bit.
//   - empty: ptrs equal.
//   - full: low bits equal and MSBs differ.
//   - Wrap from 2**ASIZE-1 to 0 is natural binary rollover.
//  Handshakes:
//   - push = i_wr_valid & o_wr_ready. On push, storage[wr_ptr] <= i_wr_data and wr_ptr increments.
//   - pop = o_rd_valid & i_rd_ready. On pop, rd_ptr increments.
//  Latency:
//   - Written data is visible on o_rd_data the cycle after the push edge (FWFT).
//   - o_rd_data is undefined when o_empty = 1.
//  Simultaneous push+pop: both occur and the count is unchanged.
//   - When full, only pop is possible (ready low).
//   - When empty, only push is possible (valid low). There is no bypass from write to read in the same cycle.
//  o_count is a register:
//   - +1 on push only, -1 on pop only, otherwise held.
//   - All flags are registered and derived from next-state count, so they are valid the cycle after the event.
//  Errors:
//   - o_ovf sets on i_wr_valid & o_full.
//   - o_unf sets on i_rd_ready & o_empty.
//   - i_clr_err clears both; a set in the same cycle wins over the clear.
//   - Rejected requests never move pointers.
// STRUCTURE
//  - Shared package: function clog2, and a default depth/width localparam pair for voice buffers.
//  - One sub-module: dualram #(ASIZE,DSIZE) as storage, with we = push, wr_addr = wr_ptr[ASIZE-1:0], rd_addr = rd_ptr[ASIZE-1:0].
//  - Pointer, count, flag and error logic live in this module.
// TESTING
//  1. Reset: assert i_rst_n = 0 mid-stream with 5 entries held -> count 0, empty 1, ovf/unf 0 asynchronously.
//  2. Fill 8 entries (ASIZE=3) with 0x10..0x17:
//     - o_full = 1 after the 8th push.
//     - o_afull = 1 after the 6th push.
//     - A 9th write sets o_ovf and leaves count at 8.
//  3. Drain all 8 entries -> data 0x10..0x17 in order; o_empty = 1 after the 8th pop; a 9th pop sets o_unf.
//  4. Hold count at 4 with push+pop every cycle for 20 cycles -> count stays 4; data order is preserved across pointer wrap.
//  5. Full and valid+ready both high -> only the pop occurs and count goes to 7. Empty and both high -> only the push occurs, count goes to 1, and o_rd_data shows the word next cycle.
//  6. Set o_ovf, then pulse i_clr_err -> o_ovf clears. Pulse i_clr_err together with a new overflow -> o_ovf stays 1.

Source files
------------

// File: rtl/voice_sync_fifo_pkg.sv
// Shared types, defaults and helpers for the voice sample FIFO.
package voice_sync_fifo_pkg;

  // Default geometry for voice sample buffers: 8 entries of 8 bits.
  localparam int unsigned VOICE_ASIZE = 3;
  localparam int unsigned VOICE_DSIZE = 8;

  // Ceiling log2; returns the bit count needed to encode values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_sync_fifo_if.sv
// Handshake, data and status bundle between the FIFO and its neighbours.
interface voice_sync_fifo_if
  import voice_sync_fifo_pkg::*;
#(
  parameter int unsigned ASIZE = VOICE_ASIZE,
  parameter int unsigned DSIZE = VOICE_DSIZE
) ();

  logic             i_wr_valid;
  logic             o_wr_ready;
  logic [DSIZE-1:0] i_wr_data;
  logic             o_rd_valid;
  logic             i_rd_ready;
  logic [DSIZE-1:0] o_rd_data;
  logic             o_full;
  logic             o_empty;
  logic             o_afull;
  logic             o_aempty;
  logic [ASIZE:0]   o_count;
  logic             o_ovf;
  logic             o_unf;
  logic             i_clr_err;

  // FIFO side
  modport slave (
    input  i_wr_valid, i_wr_data, i_rd_ready, i_clr_err,
    output o_wr_ready, o_rd_valid, o_rd_data, o_full, o_empty,
           o_afull, o_aempty, o_count, o_ovf, o_unf
  );

  // Producer/consumer side
  modport master (
    output i_wr_valid, i_wr_data, i_rd_ready, i_clr_err,
    input  o_wr_ready, o_rd_valid, o_rd_data, o_full, o_empty,
           o_afull, o_aempty, o_count, o_ovf, o_unf
  );

endinterface

// File: rtl/voice_sync_fifo_dualram.sv
// Storage array: synchronous write port, asynchronous read port.
module voice_sync_fifo_dualram #(
  parameter int unsigned ASIZE = 3,
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ASIZE-1:0] wr_addr_i,
  input  logic [DSIZE-1:0] wr_data_i,
  input  logic [ASIZE-1:0] rd_addr_i,
  output logic [DSIZE-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read port is combinational so the head word falls through
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/voice_sync_fifo.sv
// First-word-fall-through FIFO: pointers, occupancy, flags and sticky errors.
module voice_sync_fifo
  import voice_sync_fifo_pkg::*;
#(
  parameter int unsigned ASIZE     = VOICE_ASIZE,
  parameter int unsigned DSIZE     = VOICE_DSIZE,
  parameter int unsigned AFULL_TH  = 6,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  voice_sync_fifo_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  // Pointer/count width: one wrap bit above the storage address
  localparam int unsigned CW    = clog2(DEPTH + 1);

  logic          push;
  logic          pop;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Accepted transfers; rejected requests never reach the pointers
  always_comb begin
    push = bus.i_wr_valid & ~full_q;
    pop  = bus.i_rd_ready & ~empty_q;
  end

  // Next pointers, occupancy, flags and sticky errors
  always_comb begin
    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(pop);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ASIZE-1:0] == rd_ptr_d[ASIZE-1:0]) &&
               (wr_ptr_d[ASIZE] != rd_ptr_d[ASIZE]);
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));

    // A new error event in the same cycle beats the clear
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.i_clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.i_wr_valid && full_q)  ovf_d = 1'b1;
    if (bus.i_rd_ready && empty_q) unf_d = 1'b1;
  end

  // State registers; reset drops all queued entries at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  voice_sync_fifo_dualram #(
    .ASIZE (ASIZE),
    .DSIZE (DSIZE)
  ) u_ram (
    .clk_i     (i_clk),
    .we_i      (push),
    .wr_addr_i (wr_ptr_q[ASIZE-1:0]),
    .wr_data_i (bus.i_wr_data),
    .rd_addr_i (rd_ptr_q[ASIZE-1:0]),
    .rd_data_o (bus.o_rd_data)
  );

  // Status outputs straight from registers
  assign bus.o_full     = full_q;
  assign bus.o_empty    = empty_q;
  assign bus.o_wr_ready = ~full_q;
  assign bus.o_rd_valid = ~empty_q;
  assign bus.o_afull    = afull_q;
  assign bus.o_aempty   = aempty_q;
  assign bus.o_count    = count_q;
  assign bus.o_ovf      = ovf_q;
  assign bus.o_unf      = unf_q;

endmodule

// File: tb/tb_voice_sync_fifo.sv
// Scoreboard bench for voice_sync_fifo (ASIZE=3, DSIZE=8).
module tb_voice_sync_fifo;

  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   mcount;
  logic [7:0] exp_q [$];

  voice_sync_fifo_if #(.ASIZE(3), .DSIZE(8)) bus ();

  voice_sync_fifo #(
    .ASIZE     (3),
    .DSIZE     (8),
    .AFULL_TH  (6),
    .AEMPTY_TH (1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; model decides what the FIFO accepts
  task automatic drive(input logic wv, input logic [7:0] wd, input logic rr, input logic clr);
    bit do_push;
    bit do_pop;
    bus.i_wr_valid = wv;
    bus.i_wr_data  = wd;
    bus.i_rd_ready = rr;
    bus.i_clr_err  = clr;
    do_push = wv && (mcount < DEPTH);
    do_pop  = rr && (mcount > 0);
    @(posedge clk);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(wd);
    mcount = mcount + int'(do_push) - int'(do_pop);
    #1;
    bus.i_wr_valid = 1'b0;
    bus.i_rd_ready = 1'b0;
    bus.i_clr_err  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_data  = 8'h00;
    bus.i_rd_ready = 1'b0;
    bus.i_clr_err  = 1'b0;
    mcount = 0;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.o_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.o_count); end
    n_chk++; if (bus.o_empty !== 1'b1 || bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got empty=%b aempty=%b exp 1/1", bus.o_empty, bus.o_aempty); end
    n_chk++; if (bus.o_full !== 1'b0 || bus.o_afull !== 1'b0) begin n_fail++; $display("FAIL reset_full: got full=%b afull=%b exp 0/0", bus.o_full, bus.o_afull); end
    n_chk++; if (bus.o_ovf !== 1'b0 || bus.o_unf !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ovf=%b unf=%b exp 0/0", bus.o_ovf, bus.o_unf); end
    n_chk++; if (bus.o_rd_valid !== 1'b0 || bus.o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got rd_valid=%b wr_ready=%b exp 0/1", bus.o_rd_valid, bus.o_wr_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(8'h0F + k), 1'b0, 1'b0);
      n_chk++; if (bus.o_count !== 4'(mcount)) begin n_fail++; $display("FAIL fill_count: got %0d exp %0d", bus.o_count, mcount); end
      if (k == 5) begin
        n_chk++; if (bus.o_afull !== 1'b0) begin n_fail++; $display("FAIL fill_afull5: got %b exp 0", bus.o_afull); end
      end
      if (k == 6) begin
        n_chk++; if (bus.o_afull !== 1'b1) begin n_fail++; $display("FAIL fill_afull6: got %b exp 1", bus.o_afull); end
      end
      if (k == 7) begin
        n_chk++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL fill_full7: got %b exp 0", bus.o_full); end
      end
    end
    n_chk++; if (bus.o_full !== 1'b1 || bus.o_wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full8: got full=%b wr_ready=%b exp 1/0", bus.o_full, bus.o_wr_ready); end
    n_chk++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pre: got %b exp 0", bus.o_ovf); end
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    n_chk++; if (bus.o_ovf !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b exp 1", bus.o_ovf); end
    n_chk++; if (bus.o_count !== 4'd8) begin n_fail++; $display("FAIL fill_ovf_count: got %0d exp 8", bus.o_count); end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 8; k++) begin
      n_chk++; if (bus.o_rd_data !== exp_q[0]) begin n_fail++; $display("FAIL drain_data: got %h exp %h", bus.o_rd_data, exp_q[0]); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      if (k == 6) begin
        n_chk++; if (bus.o_aempty !== 1'b0) begin n_fail++; $display("FAIL drain_aempty6: got %b exp 0", bus.o_aempty); end
      end
      if (k == 7) begin
        n_chk++; if (bus.o_aempty !== 1'b1 || bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL drain_aempty7: got aempty=%b empty=%b exp 1/0", bus.o_aempty, bus.o_empty); end
      end
    end
    n_chk++; if (bus.o_empty !== 1'b1 || bus.o_rd_valid !== 1'b0 || bus.o_count !== 4'd0) begin n_fail++; $display("FAIL drain_empty: got empty=%b rd_valid=%b count=%0d exp 1/0/0", bus.o_empty, bus.o_rd_valid, bus.o_count); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++; if (bus.o_unf !== 1'b1 || bus.o_count !== 4'd0) begin n_fail++; $display("FAIL drain_unf: got unf=%b count=%0d exp 1/0", bus.o_unf, bus.o_count); end
  endtask

  task automatic test_clr_err();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_chk++; if (bus.o_ovf !== 1'b0 || bus.o_unf !== 1'b0) begin n_fail++; $display("FAIL clr_both: got ovf=%b unf=%b exp 0/0", bus.o_ovf, bus.o_unf); end
    for (int k = 0; k < 8; k++) drive(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    n_chk++; if (bus.o_ovf !== 1'b1 || bus.o_count !== 4'd8) begin n_fail++; $display("FAIL clr_set_wins: got ovf=%b count=%0d exp 1/8", bus.o_ovf, bus.o_count); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_chk++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b exp 0", bus.o_ovf); end
  endtask

  task automatic test_full_simul();
    n_chk++; if (bus.o_rd_data !== exp_q[0]) begin n_fail++; $display("FAIL fsim_data: got %h exp %h", bus.o_rd_data, exp_q[0]); end
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    n_chk++; if (bus.o_count !== 4'd7 || bus.o_full !== 1'b0 || bus.o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL fsim_count: got count=%0d full=%b wr_ready=%b exp 7/0/1", bus.o_count, bus.o_full, bus.o_wr_ready); end
    for (int k = 0; k < 7; k++) begin
      n_chk++; if (bus.o_rd_data !== exp_q[0]) begin n_fail++; $display("FAIL fsim_drain: got %h exp %h", bus.o_rd_data, exp_q[0]); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_chk++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL fsim_empty: got %b exp 1", bus.o_empty); end
  endtask

  task automatic test_empty_simul();
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    n_chk++; if (bus.o_count !== 4'd1 || bus.o_rd_valid !== 1'b1) begin n_fail++; $display("FAIL esim_count: got count=%0d rd_valid=%b exp 1/1", bus.o_count, bus.o_rd_valid); end
    n_chk++; if (bus.o_rd_data !== exp_q[0]) begin n_fail++; $display("FAIL esim_data: got %h exp %h", bus.o_rd_data, exp_q[0]); end
    n_chk++; if (bus.o_unf !== 1'b1) begin n_fail++; $display("FAIL esim_unf: got %b exp 1", bus.o_unf); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) drive(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
    n_chk++; if (bus.o_count !== 4'd4) begin n_fail++; $display("FAIL b2b_start: got %0d exp 4", bus.o_count); end
    for (int k = 0; k < 20; k++) begin
      n_chk++; if (bus.o_rd_data !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data: got %h exp %h", bus.o_rd_data, exp_q[0]); end
      drive(1'b1, 8'(8'h40 + k), 1'b1, 1'b0);
      n_chk++; if (bus.o_count !== 4'd4) begin n_fail++; $display("FAIL b2b_count: got %0d exp 4", bus.o_count); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    n_chk++; if (bus.o_count !== 4'd5 || bus.o_unf !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got count=%0d unf=%b exp 5/1", bus.o_count, bus.o_unf); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.o_count !== 4'd0 || bus.o_empty !== 1'b1 || bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL rmid_count: got count=%0d empty=%b aempty=%b exp 0/1/1", bus.o_count, bus.o_empty, bus.o_aempty); end
    n_chk++; if (bus.o_ovf !== 1'b0 || bus.o_unf !== 1'b0 || bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got ovf=%b unf=%b rd_valid=%b exp 0/0/0", bus.o_ovf, bus.o_unf, bus.o_rd_valid); end
    exp_q.delete();
    mcount = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    n_chk++; if (bus.o_count !== 4'd1 || bus.o_rd_data !== 8'hA5) begin n_fail++; $display("FAIL rmid_after: got count=%0d data=%h exp 1/a5", bus.o_count, bus.o_rd_data); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_fill();
    test_drain();
    test_clr_err();
    test_full_simul();
    test_empty_simul();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
